axi_rd_master: RTL and testbench

- AXI4 read-only initiator that turns the core's simple fetch/load request into one INCR read burst on the AXI read channels.
- Sits between the CPU front end (or the I-cache refill path) and the AXI interconnect that hosts the memory and sim_uart-style slaves.
- Supports one outstanding transaction.
- A kill input abandons a request whose result is no longer needed, while keeping the AXI protocol legal.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_rd_master.sv | 132 +++++++++++++
 tb/tb_axi_rd_master.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 widths, encodings and FSM states for the AXI read/write initiators.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] CACHE_BUF  = 4'b0010;
    localparam logic [3:0] QOS_NONE   = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } axi_state_e;

    function automatic logic [AXI_ADDR_W-1:0] align8(input logic [AXI_ADDR_W-1:0] a);
        return {a[AXI_ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/axi_rd_master.sv
// Single-outstanding AXI4 INCR read initiator for the fetch/load path.
// A kill drops the results but still completes the AR handshake and drains R.
module axi_rd_master
    import axi_pkg::*;
#(
    parameter int         BEATS    = 1,
    parameter logic [3:0] AXI_ID   = 4'd0,
    parameter logic [2:0] AXI_PROT = 3'b100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AXI_ADDR_W-1:0] req_addr,
    input  logic                  kill,
    output logic                  rsp_valid,
    output logic [AXI_DATA_W-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  rsp_last,
    output logic [AXI_ID_W-1:0]   axi_ar_id,
    output logic [AXI_ADDR_W-1:0] axi_ar_addr,
    output logic [AXI_LEN_W-1:0]  axi_ar_len,
    output logic [2:0]            axi_ar_size,
    output logic [1:0]            axi_ar_burst,
    output logic [3:0]            axi_ar_cache,
    output logic [2:0]            axi_ar_prot,
    output logic [3:0]            axi_ar_qos,
    output logic                  axi_ar_valid,
    input  logic                  axi_ar_ready,
    input  logic [AXI_ID_W-1:0]   axi_r_id,
    input  logic [AXI_DATA_W-1:0] axi_r_data,
    input  logic [1:0]            axi_r_resp,
    input  logic                  axi_r_last,
    input  logic                  axi_r_valid,
    output logic                  axi_r_ready
);

    axi_state_e            state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic                  drop_q, drop_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [AXI_DATA_W-1:0] rsp_data_q;
    logic                  rsp_err_q, rsp_last_q;
    logic                  r_hs;
    logic                  unused_ok;

    assign unused_ok = ^{axi_r_id, req_addr[2:0]};

    assign req_ready    = (state_q == ST_IDLE);
    assign axi_ar_valid = (state_q == ST_ADDR);
    assign axi_r_ready  = (state_q == ST_DATA);
    assign r_hs         = axi_r_valid && axi_r_ready;

    assign axi_ar_id    = axi_ar_valid ? AXI_ID : '0;
    assign axi_ar_addr  = axi_ar_valid ? addr_q : '0;
    assign axi_ar_len   = AXI_LEN_W'(BEATS - 1);
    assign axi_ar_size  = SIZE_8B;
    assign axi_ar_burst = BURST_INCR;
    assign axi_ar_cache = CACHE_BUF;
    assign axi_ar_prot  = AXI_PROT;
    assign axi_ar_qos   = QOS_NONE;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        // a kill landing on the beat's own handshake already suppresses it
        rsp_valid_d = r_hs && !drop_q && !kill;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                drop_d = 1'b0;
                if (req_valid && !kill) begin
                    addr_d  = align8(req_addr);
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (kill) drop_d = 1'b1;
                if (axi_ar_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (kill) drop_d = 1'b1;
                if (r_hs) cnt_d = cnt_q + 4'd1;
                if (r_hs && axi_r_last) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            if (r_hs) begin
                rsp_data_q <= axi_r_data;
                rsp_err_q  <= (axi_r_resp != RESP_OKAY);
                rsp_last_q <= axi_r_last;
            end
        end
    end

    // a slave that overruns the burst without r_last is broken; keep waiting for r_last
    always_ff @(posedge clk) begin
        if (!rst && r_hs && !axi_r_last)
            assert (cnt_q != 4'(BEATS - 1))
            else $error("axi_rd_master: BEATS reached without r_last");
    end

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: single-beat and 4-beat instances,
// with a response scoreboard per instance.
module tb_axi_rd_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic        last;
    } rsp_t;

    rsp_t q1[$];
    rsp_t q4[$];
    int   rsp_cnt1 = 0;
    int   rsp_cnt4 = 0;
    int   saved;

    logic        req_valid1, req_ready1, kill1;
    logic [31:0] req_addr1;
    logic        rsp_valid1, rsp_err1, rsp_last1;
    logic [63:0] rsp_data1;
    logic [3:0]  ar_id1, ar_cache1, ar_qos1;
    logic [31:0] ar_addr1;
    logic [7:0]  ar_len1;
    logic [2:0]  ar_size1, ar_prot1;
    logic [1:0]  ar_burst1;
    logic        ar_valid1, ar_ready1;
    logic [63:0] r_data1;
    logic [1:0]  r_resp1;
    logic        r_last1, r_valid1, r_ready1;

    logic        req_valid4, req_ready4, kill4;
    logic [31:0] req_addr4;
    logic        rsp_valid4, rsp_err4, rsp_last4;
    logic [63:0] rsp_data4;
    logic [3:0]  ar_id4, ar_cache4, ar_qos4;
    logic [31:0] ar_addr4;
    logic [7:0]  ar_len4;
    logic [2:0]  ar_size4, ar_prot4;
    logic [1:0]  ar_burst4;
    logic        ar_valid4, ar_ready4;
    logic [63:0] r_data4;
    logic [1:0]  r_resp4;
    logic        r_last4, r_valid4, r_ready4;

    axi_rd_master #(.BEATS(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr1), .kill(kill1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .rsp_err(rsp_err1), .rsp_last(rsp_last1),
        .axi_ar_id(ar_id1), .axi_ar_addr(ar_addr1),
        .axi_ar_len(ar_len1), .axi_ar_size(ar_size1),
        .axi_ar_burst(ar_burst1), .axi_ar_cache(ar_cache1),
        .axi_ar_prot(ar_prot1), .axi_ar_qos(ar_qos1),
        .axi_ar_valid(ar_valid1), .axi_ar_ready(ar_ready1),
        .axi_r_id(4'd0), .axi_r_data(r_data1),
        .axi_r_resp(r_resp1), .axi_r_last(r_last1),
        .axi_r_valid(r_valid1), .axi_r_ready(r_ready1)
    );

    axi_rd_master #(.BEATS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_addr(req_addr4), .kill(kill4),
        .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
        .rsp_err(rsp_err4), .rsp_last(rsp_last4),
        .axi_ar_id(ar_id4), .axi_ar_addr(ar_addr4),
        .axi_ar_len(ar_len4), .axi_ar_size(ar_size4),
        .axi_ar_burst(ar_burst4), .axi_ar_cache(ar_cache4),
        .axi_ar_prot(ar_prot4), .axi_ar_qos(ar_qos4),
        .axi_ar_valid(ar_valid4), .axi_ar_ready(ar_ready4),
        .axi_r_id(4'd0), .axi_r_data(r_data4),
        .axi_r_resp(r_resp4), .axi_r_last(r_last4),
        .axi_r_valid(r_valid4), .axi_r_ready(r_ready4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 20; i++) begin
            if ((which == 1 ? q1.size() : q4.size()) == 0) break;
            tick();
        end
        chk(which == 1 ? "drain1" : "drain4",
            64'(which == 1 ? q1.size() : q4.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (rsp_valid1 === 1'b1) begin
            rsp_cnt1++;
            checks++;
            assert (q1.size() != 0)
            else begin
                failures++;
                $error("FAIL rsp1_unexpected observed=pulse expected=none data=%0h", rsp_data1);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("rsp1_data", rsp_data1, e.data);
                chk("rsp1_err", 64'(rsp_err1), 64'(e.err));
                chk("rsp1_last", 64'(rsp_last1), 64'(e.last));
            end
        end
        if (rsp_valid4 === 1'b1) begin
            rsp_cnt4++;
            checks++;
            assert (q4.size() != 0)
            else begin
                failures++;
                $error("FAIL rsp4_unexpected observed=pulse expected=none data=%0h", rsp_data4);
            end
            if (q4.size() != 0) begin
                e = q4.pop_front();
                chk("rsp4_data", rsp_data4, e.data);
                chk("rsp4_err", 64'(rsp_err4), 64'(e.err));
                chk("rsp4_last", 64'(rsp_last4), 64'(e.last));
            end
        end
    end

    task automatic single_read(input logic [31:0] addr, input logic [63:0] data);
        req_valid1 = 1'b1;
        req_addr1  = addr;
        tick();
        req_valid1 = 1'b0;
        chk("t1_ar_valid", 64'(ar_valid1), 64'd1);
        chk("t1_ar_addr", 64'(ar_addr1), 64'({addr[31:3], 3'b000}));
        chk("t1_req_ready_busy", 64'(req_ready1), 64'd0);
        tick();
        tick();
        ar_ready1 = 1'b1;
        tick();
        ar_ready1 = 1'b0;
        chk("t1_ar_done", 64'(ar_valid1), 64'd0);
        chk("t1_r_ready", 64'(r_ready1), 64'd1);
        tick();
        r_valid1 = 1'b1;
        r_data1  = data;
        r_last1  = 1'b1;
        r_resp1  = 2'b00;
        q1.push_back('{data: data, err: 1'b0, last: 1'b1});
        tick();
        r_valid1 = 1'b0;
        chk("t1_req_ready_back", 64'(req_ready1), 64'd1);
        drain(1);
    endtask

    initial begin
        rst = 1'b1;
        {req_valid1, kill1, ar_ready1, r_last1, r_valid1} = '0;
        {req_valid4, kill4, ar_ready4, r_last4, r_valid4} = '0;
        req_addr1 = '0; r_data1 = '0; r_resp1 = '0;
        req_addr4 = '0; r_data4 = '0; r_resp4 = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_req_ready", 64'(req_ready1), 64'd1);
        chk("rst_ar_valid", 64'(ar_valid1), 64'd0);
        chk("rst_r_ready", 64'(r_ready1), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid1), 64'd0);
        chk("rst_ar_addr", 64'(ar_addr1), 64'd0);
        chk("rst_ar_id", 64'(ar_id1), 64'd0);
        chk("rst_ar_len1", 64'(ar_len1), 64'd0);
        chk("rst_ar_size", 64'(ar_size1), 64'd3);
        chk("rst_ar_burst", 64'(ar_burst1), 64'd1);
        chk("rst_ar_cache", 64'(ar_cache1), 64'd2);
        chk("rst_ar_prot", 64'(ar_prot1), 64'd4);
        chk("rst_ar_qos", 64'(ar_qos1), 64'd0);
        chk("rst_ar_len4", 64'(ar_len4), 64'd3);

        single_read(32'h8000_0004, 64'h1122_3344_5566_7788);
        chk("t1_rsp_count", 64'(rsp_cnt1), 64'd1);

        req_valid1 = 1'b1;
        kill1      = 1'b1;
        req_addr1  = 32'h4000_0000;
        tick();
        req_valid1 = 1'b0;
        kill1      = 1'b0;
        chk("t5_no_ar", 64'(ar_valid1), 64'd0);
        chk("t5_idle", 64'(req_ready1), 64'd1);
        tick();
        chk("t5_no_ar_later", 64'(ar_valid1), 64'd0);

        saved      = rsp_cnt1;
        req_valid1 = 1'b1;
        req_addr1  = 32'h0000_1008;
        tick();
        req_valid1 = 1'b0;
        kill1      = 1'b1;
        tick();
        kill1 = 1'b0;
        chk("t3_ar_held", 64'(ar_valid1), 64'd1);
        tick();
        chk("t3_ar_held2", 64'(ar_valid1), 64'd1);
        chk("t3_ar_addr", 64'(ar_addr1), 64'h1008);
        ar_ready1 = 1'b1;
        tick();
        ar_ready1 = 1'b0;
        chk("t3_drain_ready", 64'(r_ready1), 64'd1);
        r_valid1 = 1'b1;
        r_last1  = 1'b1;
        r_data1  = 64'hDEAD_BEEF_0000_0001;
        tick();
        r_valid1 = 1'b0;
        chk("t3_idle", 64'(req_ready1), 64'd1);
        tick();
        tick();
        chk("t3_no_rsp", 64'(rsp_cnt1), 64'(saved));

        req_valid1 = 1'b1;
        req_addr1  = 32'h0000_2000;
        tick();
        req_valid1 = 1'b0;
        ar_ready1  = 1'b1;
        tick();
        ar_ready1 = 1'b0;
        r_valid1  = 1'b1;
        r_last1   = 1'b1;
        r_data1   = 64'hDEAD_BEEF_0000_0002;
        kill1     = 1'b1;
        tick();
        r_valid1 = 1'b0;
        kill1    = 1'b0;
        tick();
        tick();
        chk("kill_last_no_rsp", 64'(rsp_cnt1), 64'(saved));
        chk("kill_last_idle", 64'(req_ready1), 64'd1);

        single_read(32'h0000_3017, 64'hCAFE_F00D_1234_5678);
        chk("after_kill_rsp_count", 64'(rsp_cnt1), 64'(saved + 1));

        req_valid4 = 1'b1;
        req_addr4  = 32'h1000_0010;
        tick();
        req_valid4 = 1'b0;
        chk("t2_ar_len", 64'(ar_len4), 64'd3);
        chk("t2_ar_addr", 64'(ar_addr4), 64'h1000_0010);
        ar_ready4 = 1'b1;
        tick();
        ar_ready4 = 1'b0;
        chk("t2_r_ready", 64'(r_ready4), 64'd1);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                r_valid4 = 1'b1;
                r_data4  = 64'hA000 + 64'(k / 2);
                r_last4  = (k / 2 == 3);
                r_resp4  = 2'b00;
                q4.push_back('{data: 64'hA000 + 64'(k / 2), err: 1'b0, last: (k / 2 == 3)});
            end else begin
                r_valid4 = 1'b0;
            end
            tick();
        end
        r_valid4 = 1'b0;
        chk("t2_req_ready_back", 64'(req_ready4), 64'd1);
        drain(4);
        chk("t2_rsp_count", 64'(rsp_cnt4), 64'd4);

        req_valid4 = 1'b1;
        req_addr4  = 32'h2000_0000;
        tick();
        req_valid4 = 1'b0;
        ar_ready4  = 1'b1;
        tick();
        ar_ready4 = 1'b0;
        for (int b = 0; b < 4; b++) begin
            r_valid4 = 1'b1;
            r_data4  = 64'hB000 + 64'(b);
            r_resp4  = (b == 0) ? 2'b10 : 2'b00;
            r_last4  = (b == 3);
            q4.push_back('{data: 64'hB000 + 64'(b), err: (b == 0), last: (b == 3)});
            tick();
        end
        r_valid4 = 1'b0;
        r_resp4  = 2'b00;
        drain(4);
        chk("t4_rsp_count", 64'(rsp_cnt4), 64'd8);

        req_valid1 = 1'b1;
        req_addr1  = 32'h0000_4000;
        tick();
        req_valid1 = 1'b0;
        ar_ready1  = 1'b1;
        tick();
        ar_ready1 = 1'b0;
        chk("t6_in_data", 64'(r_ready1), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_req_ready", 64'(req_ready1), 64'd1);
        chk("t6_r_ready", 64'(r_ready1), 64'd0);
        chk("t6_ar_valid", 64'(ar_valid1), 64'd0);
        chk("t6_rsp_valid", 64'(rsp_valid1), 64'd0);
        chk("t6_ar_addr", 64'(ar_addr1), 64'd0);
        chk("t6_rsp_data", rsp_data1, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
